// File: rtl/shift_chain_pkg.sv
// Shared definitions for the configuration shift chain (decoder head and readback tail).
package shift_chain_pkg;

    localparam int BYTE_W   = 8;
    localparam int BITCNT_W = $clog2(BYTE_W);
    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(BYTE_W - 1);

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_SEND = 1'b1
    } tx_state_e;

    // Right-justify the k most recent chain bits (held in the top of sreg), zero above them.
    function automatic logic [BYTE_W-1:0] flush_pad(input logic [BYTE_W-1:0] sreg,
                                                     input logic [BITCNT_W-1:0] k);
        logic [BITCNT_W:0] sh;
        sh = (BITCNT_W + 1)'(BYTE_W) - {1'b0, k};
        return sreg >> sh;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with head-of-queue read data and occupancy count.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     accept_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_pop;
    logic             do_push;

    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign do_pop   = pop_i && (count_q != '0);
    assign do_push  = push_i && ((count_q != FULL_CNT) || do_pop);
    assign accept_o = do_push;
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign rdata_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_chain_readback.sv
// Readback tail of the configuration shift chain: packs chain bits LSB-first into bytes,
// queues them and hands them to the UART transmitter over a ready/valid handshake.
module shift_chain_readback
    import shift_chain_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              SCLK,
    input  logic              RESET,
    input  logic              SHIFT_ENABLE,
    input  logic              SHIFT_TAIL,
    input  logic              FLUSH,
    input  logic              CLEAR,
    input  logic              UART_READY,
    output logic              TX_VALID,
    output logic [BYTE_W-1:0] TX_DATA,
    output logic              STALL,
    output logic              OVERFLOW,
    output logic [CNT_W-1:0]  BYTE_COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] STALL_TH = (AW + 1)'(DEPTH - 1);

    logic [BYTE_W-1:0]   sreg_q, sreg_d;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    logic                push;
    logic [BYTE_W-1:0]   push_data;
    logic                byte_done;

    logic [BYTE_W-1:0]   fifo_rdata;
    logic                fifo_empty;
    logic                fifo_accept;
    logic                fifo_pop;
    logic [AW:0]         fifo_count;
    logic [AW:0]         occ_next;
    logic                drop;

    tx_state_e           state_q;
    logic                tx_valid_q;
    logic [BYTE_W-1:0]   tx_data_q;
    logic                stall_q;
    logic                overflow_q;
    logic [CNT_W-1:0]    byte_count_q;

    // Packer: the same-cycle shift is applied before any flush decision.
    always_comb begin
        sreg_d    = sreg_q;
        bitcnt_d  = bitcnt_q;
        push      = 1'b0;
        push_data = '0;
        byte_done = SHIFT_ENABLE && (bitcnt_q == LAST_BIT);
        if (SHIFT_ENABLE) begin
            sreg_d   = {SHIFT_TAIL, sreg_q[BYTE_W-1:1]};
            bitcnt_d = bitcnt_q + 1'b1;
        end
        if (byte_done) begin
            push      = 1'b1;
            push_data = sreg_d;
        end else if (FLUSH && (bitcnt_d != '0)) begin
            push      = 1'b1;
            push_data = flush_pad(sreg_d, bitcnt_d);
            bitcnt_d  = '0;
        end
    end

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            sreg_q   <= '0;
            bitcnt_q <= '0;
        end else begin
            sreg_q   <= sreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk_i    (SCLK),
        .rst_i    (RESET),
        .push_i   (push),
        .wdata_i  (push_data),
        .pop_i    (fifo_pop),
        .rdata_o  (fifo_rdata),
        .empty_o  (fifo_empty),
        .accept_o (fifo_accept),
        .count_o  (fifo_count)
    );

    // Head leaves the FIFO when the output register is free now or frees on this edge.
    assign fifo_pop = !fifo_empty && ((state_q == STATE_IDLE) || UART_READY);
    assign drop     = push && !fifo_accept;

    always_comb begin
        occ_next = fifo_count;
        if (fifo_accept && !fifo_pop) begin
            occ_next = fifo_count + 1'b1;
        end else if (!fifo_accept && fifo_pop) begin
            occ_next = fifo_count - 1'b1;
        end
    end

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= STATE_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            case (state_q)
                STATE_IDLE: begin
                    if (!fifo_empty) begin
                        tx_data_q  <= fifo_rdata;
                        tx_valid_q <= 1'b1;
                        state_q    <= STATE_SEND;
                    end
                end
                STATE_SEND: begin
                    if (UART_READY) begin
                        if (!fifo_empty) begin
                            tx_data_q <= fifo_rdata;
                        end else begin
                            tx_valid_q <= 1'b0;
                            state_q    <= STATE_IDLE;
                        end
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= STATE_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            stall_q      <= 1'b0;
            overflow_q   <= 1'b0;
            byte_count_q <= '0;
        end else begin
            stall_q <= (occ_next >= STALL_TH);
            if (CLEAR) begin
                byte_count_q <= {{(CNT_W-1){1'b0}}, fifo_accept};
                overflow_q   <= drop;
            end else begin
                if (fifo_accept) begin
                    byte_count_q <= byte_count_q + 1'b1;
                end
                if (drop) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    assign TX_VALID   = tx_valid_q;
    assign TX_DATA    = tx_data_q;
    assign STALL      = stall_q;
    assign OVERFLOW   = overflow_q;
    assign BYTE_COUNT = byte_count_q;

endmodule
